// File: rtl/sobel_gx_stream.sv
// sobel_gx_stream: streaming 3x3 Sobel gradient engine.
//
// Pixels arrive in raster order over a valid/ready handshake. Two line
// buffers supply rows r-1 and r-2, and per-column partial sums are kept
// for the last two columns, so a full 3x3 window is never stored.
// A result is emitted for every interior window, (IMG_W-2)*(IMG_H-2)
// results per frame. Border windows are dropped and no padding is applied.
//
// Optional feature macro: SOBEL_MAG_EN
//   undefined : out_data = signed two's-complement Gx
//   defined   : out_data = |Gx| + |Gy| (unsigned). Latency is the same.
//
// Pipeline: accept (cycle T) -> stage 1 partial sums (T+1) -> output reg (T+2).
// The whole pipeline holds while out_valid && !out_ready.
module sobel_gx_stream #(
    parameter int IMG_W = 15,
    parameter int IMG_H = 15,
    parameter int PIX_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W+2:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             frame_done
);

    localparam int OUT_W = PIX_W + 3;
    localparam int CS_W  = PIX_W + 2;   // weighted column sum top+2*mid+bot
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_frame_done;

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;

    // Line buffers: r_lb1 holds row r-1, r_lb2 holds row r-2.
    logic [PIX_W-1:0]  r_lb1 [IMG_W];
    logic [PIX_W-1:0]  r_lb2 [IMG_W];

    // Weighted column sums of the two previous columns in the current row.
    logic [CS_W-1:0]   r_cs_d1;
    logic [CS_W-1:0]   r_cs_d2;

    // Stage 1 registers.
    logic              r_s1_valid;
    logic              r_s1_last;
    logic [CS_W-1:0]   r_s1_right;
    logic [CS_W-1:0]   r_s1_left;

    // Output stage registers.
    logic              r_out_valid;
    logic              r_out_last;
    logic [OUT_W-1:0]  r_out_data;

    logic              w_stall;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_frame_last;
    logic              w_interior;
    logic              w_out_hs_last;
    logic [PIX_W-1:0]  w_top;
    logic [PIX_W-1:0]  w_mid;
    logic [PIX_W-1:0]  w_bot;
    logic [CS_W-1:0]   w_col_sum;
    logic signed [OUT_W-1:0] w_gx;
    logic [OUT_W-1:0]  w_result;

`ifdef SOBEL_MAG_EN
    // Per-column vertical differences (bottom - top) for the Gy term.
    logic signed [PIX_W:0]   w_diff;
    logic signed [PIX_W:0]   r_df_d1;
    logic signed [PIX_W:0]   r_df_d2;
    logic signed [OUT_W-1:0] w_d0_x;
    logic signed [OUT_W-1:0] w_d1_x;
    logic signed [OUT_W-1:0] w_d2_x;
    logic signed [OUT_W-1:0] w_gy;
    logic signed [OUT_W-1:0] r_s1_gy;
    logic [OUT_W-1:0]        w_abs_gx;
    logic [OUT_W-1:0]        w_abs_gy;
`endif

    // ---------------------------------------------------------------
    // Handshake and position decode
    // ---------------------------------------------------------------
    assign w_stall      = r_out_valid && !out_ready;
    assign w_in_ready   = !w_stall && (r_state != S_FLUSH);
    assign w_accept     = in_valid && w_in_ready;
    assign w_col_last   = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last   = (r_row == ROW_W'(IMG_H - 1));
    assign w_frame_last = w_col_last && w_row_last;
    assign w_interior   = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    assign w_out_hs_last = r_out_valid && out_ready && r_out_last;

    // Current column of the window: the line buffers are read before the
    // same-cycle write lands, so they still hold rows r-2 and r-1 here.
    assign w_top = r_lb2[r_col];
    assign w_mid = r_lb1[r_col];
    assign w_bot = in_pixel;

    assign w_col_sum = {2'b00, w_top} + {1'b0, w_mid, 1'b0} + {2'b00, w_bot};

`ifdef SOBEL_MAG_EN
    assign w_diff = $signed({1'b0, w_bot}) - $signed({1'b0, w_top});
    assign w_d0_x = {{(OUT_W-PIX_W-1){w_diff[PIX_W]}},  w_diff};
    assign w_d1_x = {{(OUT_W-PIX_W-1){r_df_d1[PIX_W]}}, r_df_d1};
    assign w_d2_x = {{(OUT_W-PIX_W-1){r_df_d2[PIX_W]}}, r_df_d2};
    // Column weights 1,2,1 from left to right: Gy = d(c-2) + 2d(c-1) + d(c).
    assign w_gy   = w_d2_x + (w_d1_x <<< 1) + w_d0_x;
`endif

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    // Gx = right column weighted sum minus left column weighted sum.
    assign w_gx = $signed({1'b0, r_s1_right}) - $signed({1'b0, r_s1_left});

`ifdef SOBEL_MAG_EN
    assign w_abs_gx = w_gx[OUT_W-1]    ? -w_gx    : w_gx;
    assign w_abs_gy = r_s1_gy[OUT_W-1] ? -r_s1_gy : r_s1_gy;
    assign w_result = w_abs_gx + w_abs_gy;
`else
    assign w_result = w_gx;
`endif

    // Line buffer shift: row r-1 moves down to r-2, the new pixel becomes r-1.
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= w_mid;
            r_lb1[r_col] <= in_pixel;
        end
    end

    // Raster position counters, wrapping at the end of each row and frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Column history; stale values from the previous row at col 0/1 are
    // harmless because those positions never produce a result.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cs_d1 <= '0;
            r_cs_d2 <= '0;
        end else if (w_accept) begin
            r_cs_d1 <= w_col_sum;
            r_cs_d2 <= r_cs_d1;
        end
    end

`ifdef SOBEL_MAG_EN
    // Vertical-difference history for the Gy term.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_df_d1 <= '0;
            r_df_d2 <= '0;
        end else if (w_accept) begin
            r_df_d1 <= w_diff;
            r_df_d2 <= r_df_d1;
        end
    end
`endif

    // Stage 1: capture both column partial sums with the valid/last tag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_right <= '0;
            r_s1_left  <= '0;
`ifdef SOBEL_MAG_EN
            r_s1_gy    <= '0;
`endif
        end else if (!w_stall) begin
            r_s1_valid <= w_accept && w_interior;
            r_s1_last  <= w_accept && w_frame_last;
            if (w_accept) begin
                r_s1_right <= w_col_sum;
                r_s1_left  <= r_cs_d2;
`ifdef SOBEL_MAG_EN
                r_s1_gy    <= w_gy;
`endif
            end
        end
    end

    // Stage 2: output register, frozen while the sink stalls.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (!w_stall) begin
            r_out_valid <= r_s1_valid;
            r_out_last  <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                r_out_data <= w_result;
            end
        end
    end

    // ---------------------------------------------------------------
    // Frame control FSM
    // ---------------------------------------------------------------
    // Frame sequencing with registered busy and frame_done outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_ACTIVE;
                        r_busy  <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (w_accept && w_frame_last) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_out_hs_last) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
